// File: rtl/motor_pkg.sv
// Shared types and default constants for the motor PWM driver slice.
package motor_pkg;

  localparam int unsigned PWM_BITS_DEF = 8;
  localparam int unsigned DUTY_30_DEF  = 77;
  localparam int unsigned DUTY_50_DEF  = 128;
  localparam int unsigned DUTY_100_DEF = 255;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    HOLD
  } motor_state_e;

endpackage

// File: rtl/motor_pwm_driver_pwm_core.sv
// PWM counter (0..2^PWM_BITS-2), period-boundary flag and registered comparator.
module pwm_core
  import motor_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                kill,
  output logic                pwm_out,
  output logic                boundary
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                pwm_q, pwm_d;

  // boundary marks the last count, so a duty update lands exactly as cnt wraps to 0
  always_comb begin
    boundary = (cnt_q == CNT_LAST);
    cnt_d    = boundary ? '0 : cnt_q + 1'b1;
    pwm_d    = !kill && (cnt_q < duty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Level-flag to PWM motor driver with one-LSB duty slew at period boundaries.
// Optional build macro MOTOR_PWM_BRAKE_EN: enable low brakes duty and output to 0 at once.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned STEP_DIV = 4,
  parameter int unsigned DUTY_30  = DUTY_30_DEF,
  parameter int unsigned DUTY_50  = DUTY_50_DEF,
  parameter int unsigned DUTY_100 = DUTY_100_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                lvl_30,
  input  logic                lvl_50,
  input  logic                lvl_100,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty_cur,
  output logic                at_target,
  output logic                fault
);

  localparam int unsigned         PER_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PER_W-1:0]    PER_LAST = PER_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] D30      = PWM_BITS'(DUTY_30);
  localparam logic [PWM_BITS-1:0] D50      = PWM_BITS'(DUTY_50);
  localparam logic [PWM_BITS-1:0] D100     = PWM_BITS'(DUTY_100);

  logic [PWM_BITS-1:0] target_q, target_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic                fault_q, fault_d;
  motor_state_e        state_q, state_d;
  logic [1:0]          n_lvl;
  logic                boundary, step_tick, brake;

  always_comb begin
    n_lvl   = {1'b0, lvl_30} + {1'b0, lvl_50} + {1'b0, lvl_100};
    fault_d = (n_lvl > 2'd1);
    target_d = target_q;
    if (!enable || n_lvl == 2'd0) begin
      target_d = '0;
    end else if (n_lvl == 2'd1) begin
      if (lvl_30)      target_d = D30;
      else if (lvl_50) target_d = D50;
      else             target_d = D100;
    end
  end

`ifdef MOTOR_PWM_BRAKE_EN
  assign brake = !enable;
`else
  assign brake = 1'b0;
`endif

  // Each tick steps toward the live target, so the next state is re-derived
  // from where the duty lands rather than from per-state transition arcs.
  always_comb begin
    step_tick = boundary && (per_q == PER_LAST);
    per_d     = per_q;
    if (boundary) per_d = (per_q == PER_LAST) ? '0 : per_q + 1'b1;

    duty_d = duty_q;
    if (brake) begin
      duty_d = '0;
    end else if (step_tick) begin
      if (target_q > duty_q)      duty_d = duty_q + 1'b1;
      else if (target_q < duty_q) duty_d = duty_q - 1'b1;
    end

    if (brake)                  state_d = IDLE;
    else if (duty_d == target_q) state_d = (target_q == '0) ? IDLE : HOLD;
    else if (target_q > duty_d) state_d = RAMP_UP;
    else                        state_d = RAMP_DOWN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= '0;
      duty_q   <= '0;
      per_q    <= '0;
      fault_q  <= 1'b0;
      state_q  <= IDLE;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
      per_q    <= per_d;
      fault_q  <= fault_d;
      state_q  <= state_d;
    end
  end

  pwm_core #(
    .PWM_BITS(PWM_BITS)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .duty     (duty_q),
    .kill     (brake),
    .pwm_out  (pwm_out),
    .boundary (boundary)
  );

  assign duty_cur  = duty_q;
  assign fault     = fault_q;
  assign at_target = ((state_q == HOLD) || (state_q == IDLE)) && (duty_q == target_q);

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: an 8-bit and a 4-bit instance share stimulus,
// a per-cycle behavioural model checks both, literal checks pin key points.
module tb_motor_pwm_driver;

  logic clk = 1'b0;
  logic reset, enable, lvl_30, lvl_50, lvl_100;
  logic       pwm_b, at_b, fault_b;
  logic [7:0] duty_b;
  logic       pwm_s, at_s, fault_s;
  logic [3:0] duty_s;

  always #5 clk = ~clk;

  motor_pwm_driver #(
    .PWM_BITS(8), .STEP_DIV(1), .DUTY_30(77), .DUTY_50(128), .DUTY_100(255)
  ) u_big (
    .clk(clk), .reset(reset), .enable(enable), .lvl_30(lvl_30), .lvl_50(lvl_50),
    .lvl_100(lvl_100), .pwm_out(pwm_b), .duty_cur(duty_b), .at_target(at_b), .fault(fault_b)
  );

  motor_pwm_driver #(
    .PWM_BITS(4), .STEP_DIV(2), .DUTY_30(4), .DUTY_50(8), .DUTY_100(15)
  ) u_small (
    .clk(clk), .reset(reset), .enable(enable), .lvl_30(lvl_30), .lvl_50(lvl_50),
    .lvl_100(lvl_100), .pwm_out(pwm_s), .duty_cur(duty_s), .at_target(at_s), .fault(fault_s)
  );

`ifdef MOTOR_PWM_BRAKE_EN
  localparam bit BRAKE = 1'b1;
`else
  localparam bit BRAKE = 1'b0;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit checking = 1'b0;

  // per-instance spec parameters: period length, step divider, level duties
  int PERIOD[2] = '{255, 15};
  int SD[2]     = '{1, 2};
  int DV30[2]   = '{77, 4};
  int DV50[2]   = '{128, 8};
  int DV100[2]  = '{255, 15};

  int m_cnt[2], m_per[2], m_duty[2], m_tgt[2];
  bit m_pwm[2], m_fault[2], m_at[2];
  int nl, nt, nd;
  bit tick, brk;

  // Model: one clock of the spec's rules, evaluated from pre-edge values.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cnt[k] = 0; m_per[k] = 0; m_duty[k] = 0; m_tgt[k] = 0;
        m_pwm[k] = 1'b0; m_fault[k] = 1'b0; m_at[k] = 1'b1;
        checking = 1'b1;
      end else begin
        nl   = int'(lvl_30) + int'(lvl_50) + int'(lvl_100);
        brk  = BRAKE && !enable;
        tick = (m_cnt[k] == PERIOD[k] - 1) && (m_per[k] == SD[k] - 1);
        m_pwm[k] = !brk && (m_cnt[k] < m_duty[k]);
        nd = m_duty[k];
        if (brk) nd = 0;
        else if (tick && m_tgt[k] > nd) nd = nd + 1;
        else if (tick && m_tgt[k] < nd) nd = nd - 1;
        if (!enable || nl == 0) nt = 0;
        else if (nl == 1) nt = lvl_30 ? DV30[k] : (lvl_50 ? DV50[k] : DV100[k]);
        else nt = m_tgt[k];
        m_at[k]    = (nd == nt) && (brk || nd == m_tgt[k]);
        m_fault[k] = (nl > 1);
        if (m_cnt[k] == PERIOD[k] - 1) begin
          m_cnt[k] = 0;
          m_per[k] = (m_per[k] == SD[k] - 1) ? 0 : m_per[k] + 1;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
        m_duty[k] = nd;
        m_tgt[k]  = nt;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    chk(name, act, exp);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      chk("big_pwm",   32'(pwm_b),   32'(m_pwm[0]));
      chk("big_duty",  32'(duty_b),  m_duty[0]);
      chk("big_at",    32'(at_b),    32'(m_at[0]));
      chk("big_fault", 32'(fault_b), 32'(m_fault[0]));
      chk("sml_pwm",   32'(pwm_s),   32'(m_pwm[1]));
      chk("sml_duty",  32'(duty_s),  m_duty[1]);
      chk("sml_at",    32'(at_s),    32'(m_at[1]));
      chk("sml_fault", 32'(fault_s), 32'(m_fault[1]));
    end
  end

  task automatic next_edge(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_duty(input int k, input int val, input int budget, input string name);
    int i;
    i = 0;
    while (((k == 0) ? int'(duty_b) : int'(duty_s)) != val && i < budget) begin
      @(negedge clk);
      i++;
    end
    lit(name, (k == 0) ? 32'(duty_b) : 32'(duty_s), val);
  endtask

  int hi_b, hi_s, db;

  initial begin
    reset = 1'b1; enable = 1'b0; lvl_30 = 1'b0; lvl_50 = 1'b0; lvl_100 = 1'b0;
    next_edge(3);
    lit("rst_pwm", 32'(pwm_b), 0);
    lit("rst_duty", 32'(duty_b), 0);
    lit("rst_at", 32'(at_b), 1);
    lit("rst_fault", 32'(fault_b), 0);
    reset = 1'b0;
    next_edge(600);
    lit("idle_duty_big", 32'(duty_b), 0);
    lit("idle_at_small", 32'(at_s), 1);

    enable = 1'b1; lvl_50 = 1'b1;
    wait_duty(0, 40, 45 * 255, "ramp_to_40");
    next_edge(1);
    reset = 1'b1;
    next_edge(1);
    lit("midramp_rst_duty", 32'(duty_b), 0);
    lit("midramp_rst_at", 32'(at_b), 1);
    reset = 1'b0;
    wait_duty(0, 128, 130 * 255, "ramp_to_128");
    lit("hold128_at", 32'(at_b), 1);
    hi_b = 0; hi_s = 0;
    repeat (255) begin
      @(negedge clk);
      hi_b += int'(pwm_b);
      hi_s += int'(pwm_s);
    end
    lit("big_high_per_period", hi_b, 128);
    lit("small_high_17_periods", hi_s, 136);

    next_edge(1);
    lvl_50 = 1'b0; lvl_30 = 1'b1; lvl_100 = 1'b1;
    next_edge(1);
    lit("fault_set", 32'(fault_b), 1);
    next_edge(300);
    lit("fault_duty_held", 32'(duty_b), 128);
    lvl_100 = 1'b0;
    next_edge(1);
    lit("fault_clear", 32'(fault_b), 0);
    wait_duty(0, 77, 60 * 255, "ramp_down_77");
    lit("hold77_at", 32'(at_b), 1);

    next_edge(1);
    lvl_30 = 1'b0; lvl_100 = 1'b1;
    wait_duty(1, 15, 600, "small_ramp_15");
    hi_s = 0;
    repeat (45) begin
      @(negedge clk);
      hi_s += int'(pwm_s);
    end
    lit("small_const_high", hi_s, 45);

    next_edge(1);
    db = int'(duty_b);
    enable = 1'b0;
    next_edge(1);
`ifdef MOTOR_PWM_BRAKE_EN
    lit("brake_duty", 32'(duty_b), 0);
    lit("brake_pwm", 32'(pwm_b), 0);
`else
    lit("no_brake_duty_nonzero", 32'(duty_b != 8'd0), 1);
`endif
    wait_duty(1, 0, 600, "small_slew_to_0");
    next_edge(1);
    lit("small_idle_at", 32'(at_s), 1);
    next_edge(2 * 255);
    lit("big_slewing_down", 32'(int'(duty_b) < db), 1);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
